// File: rtl/memory_stage_if.sv
// Data-memory request/response bus between the memory stage (master) and the data memory (slave).
interface memory_stage_if #(
    parameter int unsigned REG_WIDTH = 16
);
    logic                 O_DMemReq;
    logic                 O_DMemWe;
    logic [REG_WIDTH-2:0] O_DMemAddr;
    logic [REG_WIDTH-1:0] O_DMemWData;
    logic [1:0]           O_DMemByteEn;
    logic                 I_DMemAck;
    logic [REG_WIDTH-1:0] I_DMemRData;

    modport master (
        output O_DMemReq, O_DMemWe, O_DMemAddr, O_DMemWData, O_DMemByteEn,
        input  I_DMemAck, I_DMemRData
    );

    modport slave (
        input  O_DMemReq, O_DMemWe, O_DMemAddr, O_DMemWData, O_DMemByteEn,
        output I_DMemAck, I_DMemRData
    );
endinterface

// File: rtl/memory_stage.sv
// Pipeline memory stage: passes ALU results to writeback and runs one data-memory access per
// load/store, waiting a bounded number of cycles for the ack before flagging a sticky error.
module memory_stage #(
    parameter  int unsigned MAX_WAIT     = 15,
    localparam int unsigned PC_WIDTH     = 16,
    localparam int unsigned IR_WIDTH     = 16,
    localparam int unsigned OPCODE_WIDTH = 4,
    localparam int unsigned REG_WIDTH    = 16,
    localparam int unsigned CNT_WIDTH    = (MAX_WAIT == 0) ? 1 : $clog2(MAX_WAIT + 1)
) (
    input  logic                    I_CLOCK,
    input  logic                    I_RESET_N,
    input  logic                    I_LOCK,
    input  logic [PC_WIDTH-1:0]     I_PC,
    input  logic [IR_WIDTH-1:0]     I_IR,
    input  logic [OPCODE_WIDTH-1:0] I_Opcode,
    input  logic [3:0]              I_DestRegIdx,
    input  logic [REG_WIDTH-1:0]    I_DestValue,
    input  logic [2:0]              I_CCValue,
    input  logic                    I_EX_Valid,
    input  logic                    I_RegWEn,
    input  logic                    I_CCWEn,
    input  logic [REG_WIDTH-1:0]    I_MARValue,
    input  logic [REG_WIDTH-1:0]    I_MDRValue,
    memory_stage_if.master          dmem,
    output logic                    O_MEMStallSignal,
    output logic                    O_RegWEn_Signal,
    output logic                    O_LOCK,
    output logic [PC_WIDTH-1:0]     O_PC,
    output logic [IR_WIDTH-1:0]     O_IR,
    output logic [OPCODE_WIDTH-1:0] O_Opcode,
    output logic [3:0]              O_DestRegIdx,
    output logic [REG_WIDTH-1:0]    O_DestValue,
    output logic [2:0]              O_CCValue,
    output logic                    O_MEM_Valid,
    output logic                    O_RegWEn,
    output logic                    O_CCWEn,
    output logic                    O_MemErr
);
    localparam logic [OPCODE_WIDTH-1:0] OP_LDB = OPCODE_WIDTH'(4'h2);
    localparam logic [OPCODE_WIDTH-1:0] OP_STB = OPCODE_WIDTH'(4'h3);
    localparam logic [OPCODE_WIDTH-1:0] OP_LDW = OPCODE_WIDTH'(4'h6);
    localparam logic [OPCODE_WIDTH-1:0] OP_STW = OPCODE_WIDTH'(4'h7);

    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_e;

    state_e                  state_q, state_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic                    req_q, req_d, we_q, we_d;
    logic [REG_WIDTH-2:0]    addr_q, addr_d;
    logic [REG_WIDTH-1:0]    wdata_q, wdata_d;
    logic [1:0]              byte_en_q, byte_en_d;
    logic                    mar0_q, mar0_d, pend_regwen_q, pend_regwen_d, pend_ccwen_q, pend_ccwen_d;
    logic                    lock_q, lock_d, valid_q, valid_d, regwen_q, regwen_d;
    logic                    ccwen_q, ccwen_d, mem_err_q, mem_err_d;
    logic [PC_WIDTH-1:0]     pc_q, pc_d;
    logic [IR_WIDTH-1:0]     ir_q, ir_d;
    logic [OPCODE_WIDTH-1:0] opcode_q, opcode_d;
    logic [3:0]              dest_idx_q, dest_idx_d;
    logic [REG_WIDTH-1:0]    dest_value_q, dest_value_d;
    logic [2:0]              cc_q, cc_d;

    logic                    is_load, is_store, is_word, memop;
    logic [7:0]              load_byte;
    logic [REG_WIDTH-1:0]    load_val;

    // Instruction decode and the load result for the access in flight.
    always_comb begin : decode
        is_load   = (I_Opcode == OP_LDB) || (I_Opcode == OP_LDW);
        is_store  = (I_Opcode == OP_STB) || (I_Opcode == OP_STW);
        is_word   = (I_Opcode == OP_LDW) || (I_Opcode == OP_STW);
        memop     = (is_load || is_store) && I_EX_Valid && I_LOCK;
        load_byte = mar0_q ? dmem.I_DMemRData[15:8] : dmem.I_DMemRData[7:0];
        load_val  = (opcode_q == OP_LDW) ? dmem.I_DMemRData : {{(REG_WIDTH-8){1'b0}}, load_byte};
    end

    // Stall and register-write hints consumed combinationally by execute/decode.
    always_comb begin : hints
        O_MEMStallSignal = (state_q == IDLE) ? memop : !dmem.I_DMemAck;
        O_RegWEn_Signal  = (state_q == IDLE) ? (!is_store && I_RegWEn && I_EX_Valid && I_LOCK)
                                             : !we_q;
    end

    always_comb begin : next_state
        state_d       = state_q;
        cnt_d         = cnt_q;
        req_d         = req_q;
        we_d          = we_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        byte_en_d     = byte_en_q;
        mar0_d        = mar0_q;
        pend_regwen_d = pend_regwen_q;
        pend_ccwen_d  = pend_ccwen_q;
        lock_d        = I_LOCK;
        pc_d          = pc_q;
        ir_d          = ir_q;
        opcode_d      = opcode_q;
        dest_idx_d    = dest_idx_q;
        dest_value_d  = dest_value_q;
        cc_d          = cc_q;
        valid_d       = 1'b0;
        regwen_d      = 1'b0;
        ccwen_d       = 1'b0;
        mem_err_d     = mem_err_q;
        case (state_q)
            IDLE: begin
                // Bundle is captured on every IDLE edge; a memop keeps it parked until completion.
                pc_d         = I_PC;
                ir_d         = I_IR;
                opcode_d     = I_Opcode;
                dest_idx_d   = I_DestRegIdx;
                dest_value_d = I_DestValue;
                cc_d         = I_CCValue;
                if (memop) begin
                    state_d       = WAIT;
                    cnt_d         = '0;
                    req_d         = 1'b1;
                    we_d          = is_store;
                    addr_d        = I_MARValue[REG_WIDTH-1:1];
                    wdata_d       = is_word ? I_MDRValue : {2{I_MDRValue[7:0]}};
                    byte_en_d     = is_word ? 2'b11 : (I_MARValue[0] ? 2'b10 : 2'b01);
                    mar0_d        = I_MARValue[0];
                    pend_regwen_d = I_RegWEn;
                    pend_ccwen_d  = I_CCWEn;
                end else if (I_LOCK) begin
                    valid_d  = I_EX_Valid;
                    regwen_d = I_RegWEn && I_EX_Valid;
                    ccwen_d  = I_CCWEn && I_EX_Valid;
                end
            end
            WAIT: begin
                if (dmem.I_DMemAck) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    valid_d = 1'b1;
                    if (!we_q) begin
                        dest_value_d = load_val;
                        regwen_d     = pend_regwen_q;
                        ccwen_d      = pend_ccwen_q;
                        if (pend_ccwen_q) begin
                            cc_d = load_val[REG_WIDTH-1] ? 3'b100 :
                                   (load_val == '0)      ? 3'b010 : 3'b001;
                        end
                    end
                end else if (cnt_q == CNT_WIDTH'(MAX_WAIT - 1)) begin
                    state_d   = IDLE;
                    req_d     = 1'b0;
                    we_d      = 1'b0;
                    valid_d   = 1'b1;
                    mem_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(negedge I_CLOCK) begin : regs
        if (!I_RESET_N) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            req_q         <= 1'b0;
            we_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            byte_en_q     <= 2'b00;
            mar0_q        <= 1'b0;
            pend_regwen_q <= 1'b0;
            pend_ccwen_q  <= 1'b0;
            lock_q        <= 1'b0;
            pc_q          <= '0;
            ir_q          <= '0;
            opcode_q      <= '0;
            dest_idx_q    <= '0;
            dest_value_q  <= '0;
            cc_q          <= '0;
            valid_q       <= 1'b0;
            regwen_q      <= 1'b0;
            ccwen_q       <= 1'b0;
            mem_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            req_q         <= req_d;
            we_q          <= we_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            byte_en_q     <= byte_en_d;
            mar0_q        <= mar0_d;
            pend_regwen_q <= pend_regwen_d;
            pend_ccwen_q  <= pend_ccwen_d;
            lock_q        <= lock_d;
            pc_q          <= pc_d;
            ir_q          <= ir_d;
            opcode_q      <= opcode_d;
            dest_idx_q    <= dest_idx_d;
            dest_value_q  <= dest_value_d;
            cc_q          <= cc_d;
            valid_q       <= valid_d;
            regwen_q      <= regwen_d;
            ccwen_q       <= ccwen_d;
            mem_err_q     <= mem_err_d;
        end
    end

    assign dmem.O_DMemReq    = req_q;
    assign dmem.O_DMemWe     = we_q;
    assign dmem.O_DMemAddr   = addr_q;
    assign dmem.O_DMemWData  = wdata_q;
    assign dmem.O_DMemByteEn = byte_en_q;
    assign O_LOCK            = lock_q;
    assign O_PC              = pc_q;
    assign O_IR              = ir_q;
    assign O_Opcode          = opcode_q;
    assign O_DestRegIdx      = dest_idx_q;
    assign O_DestValue       = dest_value_q;
    assign O_CCValue         = cc_q;
    assign O_MEM_Valid       = valid_q;
    assign O_RegWEn          = regwen_q;
    assign O_CCWEn           = ccwen_q;
    assign O_MemErr          = mem_err_q;
endmodule

// File: tb/tb_memory_stage.sv
// Directed and randomized checks of memory_stage against a transaction-level model of each op.
module tb_memory_stage;
    localparam int unsigned MW = 4;
    localparam logic [3:0] OP_ADD = 4'h1, OP_AND = 4'h5;
    localparam logic [3:0] OP_LDB = 4'h2, OP_STB = 4'h3, OP_LDW = 4'h6, OP_STW = 4'h7;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_lock = 1'b0, i_ex_valid = 1'b0, i_regwen = 1'b0, i_ccwen = 1'b0;
    logic [15:0] i_pc = '0, i_ir = '0, i_dest_value = '0, i_mar = '0, i_mdr = '0;
    logic [3:0]  i_opcode = '0, i_dest_idx = '0;
    logic [2:0]  i_cc = '0;
    logic        stall, regwen_sig, o_lock, o_valid, o_regwen, o_ccwen, o_memerr;
    logic [15:0] o_pc, o_ir, o_dest_value;
    logic [3:0]  o_opcode, o_dest_idx;
    logic [2:0]  o_cc;

    int   tests = 0;
    int   fails = 0;
    logic err_exp = 1'b0;

    memory_stage_if #(.REG_WIDTH(16)) dmem ();

    memory_stage #(.MAX_WAIT(MW)) dut (
        .I_CLOCK(clk), .I_RESET_N(rst_n), .I_LOCK(i_lock), .I_PC(i_pc), .I_IR(i_ir),
        .I_Opcode(i_opcode), .I_DestRegIdx(i_dest_idx), .I_DestValue(i_dest_value),
        .I_CCValue(i_cc), .I_EX_Valid(i_ex_valid), .I_RegWEn(i_regwen), .I_CCWEn(i_ccwen),
        .I_MARValue(i_mar), .I_MDRValue(i_mdr), .dmem(dmem),
        .O_MEMStallSignal(stall), .O_RegWEn_Signal(regwen_sig), .O_LOCK(o_lock),
        .O_PC(o_pc), .O_IR(o_ir), .O_Opcode(o_opcode), .O_DestRegIdx(o_dest_idx),
        .O_DestValue(o_dest_value), .O_CCValue(o_cc), .O_MEM_Valid(o_valid),
        .O_RegWEn(o_regwen), .O_CCWEn(o_ccwen), .O_MemErr(o_memerr)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One state-update edge (negedge), then return at the posedge where outputs are sampled.
    task automatic tick();
        @(negedge clk);
        @(posedge clk);
    endtask

    function automatic logic [15:0] loaded(input logic [3:0] op, input logic [15:0] mar,
                                           input logic [15:0] rdata);
        if (op == OP_LDW) return rdata;
        return mar[0] ? (rdata >> 8) : (rdata & 16'h00FF);
    endfunction

    function automatic logic [2:0] sign_cc(input logic [15:0] v);
        if ($signed(v) < 0) return 3'b100;
        if (v == 16'd0) return 3'b010;
        return 3'b001;
    endfunction

    task automatic do_reset();
        i_lock = 1'b1; i_ex_valid = 1'b1; i_opcode = OP_LDW; i_regwen = 1'b1;
        i_dest_value = 16'hFFFF; i_pc = 16'h1234; dmem.I_DMemAck = 1'b1;
        rst_n = 1'b0;
        tick();
        chk("reset_ctrl", {dmem.O_DMemReq, dmem.O_DMemWe, dmem.O_DMemByteEn, o_valid, o_regwen,
                           o_ccwen, o_memerr, o_lock}, 64'd0);
        chk("reset_pc_ir", {o_pc, o_ir}, 64'd0);
        chk("reset_bundle", {o_opcode, o_dest_idx, o_cc, o_dest_value}, 64'd0);
        rst_n = 1'b1; i_ex_valid = 1'b0; dmem.I_DMemAck = 1'b0;
        err_exp = 1'b0;
        tick();
    endtask

    // Issue one instruction and follow it to completion, checking against the op's rules.
    task automatic run_op(input logic [3:0] op, input logic lk, input logic v, input logic rw,
                          input logic cw, input logic [15:0] dv, input logic [15:0] mar,
                          input logic [15:0] mdr, input logic [2:0] cc, input int delay,
                          input logic [15:0] rdata, input logic idle_ack);
        logic is_ld, is_st, is_mem, done;
        logic [15:0] pc, ir, lv;
        logic [3:0] di;
        logic lk_now;
        pc = 16'($urandom); ir = 16'($urandom); di = 4'($urandom);
        is_ld  = (op == OP_LDB) || (op == OP_LDW);
        is_st  = (op == OP_STB) || (op == OP_STW);
        is_mem = (is_ld || is_st) && v && lk;
        i_opcode = op; i_lock = lk; i_ex_valid = v; i_regwen = rw; i_ccwen = cw;
        i_dest_value = dv; i_mar = mar; i_mdr = mdr; i_cc = cc; i_pc = pc; i_ir = ir;
        i_dest_idx = di; dmem.I_DMemAck = idle_ack; dmem.I_DMemRData = 16'($urandom);
        #1;
        chk("stall_issue", stall, is_mem);
        chk("regwen_sig_issue", regwen_sig, !is_st && rw && v && lk);
        tick();
        chk("lock_issue", o_lock, lk);
        chk("memerr_issue", o_memerr, err_exp);
        if (!is_mem) begin
            chk("req_idle", dmem.O_DMemReq, 1'b0);
            chk("valid_idle", {o_valid, o_regwen, o_ccwen}, {v && lk, rw && v && lk, cw && v && lk});
            if (lk) chk("bundle_idle", {o_pc, o_dest_value, o_cc, o_dest_idx}, {pc, dv, cc, di});
            return;
        end
        chk("req_issue", {dmem.O_DMemReq, dmem.O_DMemWe, dmem.O_DMemAddr}, {1'b1, is_st, 15'(mar >> 1)});
        chk("bubble_issue", {o_valid, o_regwen, o_ccwen}, 3'b000);
        if (is_st) begin
            chk("wdata", dmem.O_DMemWData, (op == OP_STW) ? mdr : {mdr[7:0], mdr[7:0]});
            chk("byte_en", dmem.O_DMemByteEn, (op == OP_STW) ? 2'b11 : (mar[0] ? 2'b10 : 2'b01));
        end
        done = 1'b0;
        for (int k = 0; k < int'(MW) && !done; k++) begin
            dmem.I_DMemAck = (k == delay);
            dmem.I_DMemRData = rdata;
            lk_now = 1'($urandom);
            i_lock = lk_now;
            #1;
            chk("stall_wait", stall, k != delay);
            chk("regwen_sig_wait", regwen_sig, is_ld);
            tick();
            chk("lock_wait", o_lock, lk_now);
            if (k == delay) begin
                done = 1'b1;
                chk("done", {dmem.O_DMemReq, o_valid, o_memerr, o_pc, o_opcode}, {1'b0, 1'b1, err_exp, pc, op});
                if (is_ld) begin
                    lv = loaded(op, mar, rdata);
                    chk("load_value", o_dest_value, lv);
                    chk("load_flags", {o_regwen, o_ccwen}, {rw, cw});
                    chk("load_cc", o_cc, cw ? sign_cc(lv) : cc);
                end else begin
                    chk("store_flags", {o_regwen, o_ccwen}, 2'b00);
                end
            end else if (k + 1 == int'(MW)) begin
                done = 1'b1;
                err_exp = 1'b1;
                chk("timeout", {dmem.O_DMemReq, o_valid, o_regwen, o_ccwen, o_memerr}, 5'b01001);
            end else begin
                chk("wait_hold", {dmem.O_DMemReq, o_valid, dmem.O_DMemAddr}, {1'b1, 1'b0, 15'(mar >> 1)});
            end
        end
        dmem.I_DMemAck = 1'b0;
    endtask

    initial begin
        logic [3:0] op;
        dmem.I_DMemAck = 1'b0;
        dmem.I_DMemRData = '0;
        @(posedge clk);
        do_reset();
        // ALU pass-through, then ALU with a stray ack in IDLE.
        run_op(OP_ADD, 1, 1, 1, 0, 16'h0005, 16'h0, 16'h0, 3'b001, 0, 16'h0, 1'b0);
        run_op(OP_AND, 1, 1, 1, 1, 16'h8001, 16'h0, 16'h0, 3'b100, 0, 16'h0, 1'b1);
        // LDB high byte, ack one cycle after the request.
        run_op(OP_LDB, 1, 1, 1, 1, 16'h0, 16'h0011, 16'h0, 3'b010, 1, 16'hAB80, 1'b0);
        // STB low lane, immediate ack.
        run_op(OP_STB, 1, 1, 1, 1, 16'h0, 16'h0010, 16'h12CD, 3'b010, 0, 16'h0, 1'b0);
        // Ack on the last allowed cycle completes normally.
        run_op(OP_LDW, 1, 1, 1, 1, 16'h0, 16'h0021, 16'h0, 3'b001, int'(MW) - 1, 16'h0000, 1'b0);
        // No ack: timeout, then the error stays set across later ops.
        run_op(OP_LDW, 1, 1, 1, 1, 16'h0, 16'h0040, 16'h0, 3'b001, 99, 16'h0, 1'b0);
        run_op(OP_ADD, 1, 1, 1, 0, 16'h0007, 16'h0, 16'h0, 3'b001, 0, 16'h0, 1'b0);
        // Locked-out STW starts no access.
        run_op(OP_STW, 0, 1, 0, 0, 16'h0, 16'h0030, 16'hBEEF, 3'b001, 0, 16'h0, 1'b0);
        // Reset mid-access abandons it; a later ack is ignored.
        do_reset();
        run_op(OP_LDW, 1, 1, 1, 0, 16'h0, 16'h0050, 16'h0, 3'b001, 99, 16'h0, 1'b0);
        do_reset();
        i_opcode = OP_LDW; i_lock = 1'b1; i_ex_valid = 1'b1; i_regwen = 1'b1; i_mar = 16'h0060;
        tick();
        chk("rst_wait_req", dmem.O_DMemReq, 1'b1);
        rst_n = 1'b0;
        tick();
        chk("rst_wait_cleared", {dmem.O_DMemReq, o_valid, o_memerr}, 3'b000);
        rst_n = 1'b1; i_ex_valid = 1'b0; dmem.I_DMemAck = 1'b1; dmem.I_DMemRData = 16'h5555;
        #1;
        chk("rst_wait_stall", stall, 1'b0);
        tick();
        chk("rst_late_ack", {dmem.O_DMemReq, o_valid, o_regwen}, 3'b000);
        dmem.I_DMemAck = 1'b0;
        tick();
        // Randomized op mix with random ack delays, lock/valid gating and occasional resets.
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 5))
                0: op = OP_ADD;
                1: op = OP_AND;
                2: op = OP_LDB;
                3: op = OP_LDW;
                4: op = OP_STB;
                default: op = OP_STW;
            endcase
            if ($urandom_range(0, 19) == 0) do_reset();
            run_op(op, $urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0, 1'($urandom),
                   1'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 3'($urandom),
                   int'($urandom_range(0, 5)), 16'($urandom), 1'($urandom));
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
